// File: rtl/tap_fir4.sv
// tap_fir4 -- two-stage pipelined 4-tap FIR on the outputs of a 4-stage
// delay line. Constant 4-bit unsigned coefficients, round-half-up, then
// right shift by SHIFT, then unsigned saturation to 8 bits. A warm-up
// counter marks results valid only once the delay line holds real samples
// and the pipeline has flushed. A peak-hold register and a threshold flag
// feed the control path.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (clears every register)
//   tap0..tap3 delay-line samples, tap0 newest, tap3 oldest, unsigned 8 bit
//   thresh     compare level for 'above', unsigned 8 bit
//   peak_clr   synchronous clear of 'peak' (wins over a capture)
//   dout       filtered, rounded, saturated sample (2 clocks after taps)
//   out_valid  dout carries a fully-populated filter result
//   above      out_valid and dout > thresh (strict)
//   peak       largest valid dout since reset or last clear (lags dout 1 clk)
module tap_fir4 #(
    parameter logic [3:0] C0    = 4'd1,
    parameter logic [3:0] C1    = 4'd2,
    parameter logic [3:0] C2    = 4'd2,
    parameter logic [3:0] C3    = 4'd1,
    parameter int unsigned SHIFT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tap0,
    input  logic [7:0] tap1,
    input  logic [7:0] tap2,
    input  logic [7:0] tap3,
    input  logic [7:0] thresh,
    input  logic       peak_clr,
    output logic [7:0] dout,
    output logic       out_valid,
    output logic       above,
    output logic [7:0] peak
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned COEF_W = 4;
    localparam int unsigned PROD_W = DATA_W + COEF_W;   // 12
    localparam int unsigned SUM_W  = PROD_W + 2;         // 14, holds 4*15*255 + 32
    localparam logic [2:0]  WARM_DONE = 3'd6;            // 4 fill edges + 2 pipeline edges

    // Round half up, then drop SHIFT LSBs. Worst-case sum plus the rounding
    // constant still fits SUM_W, so nothing is lost before saturation.
    function automatic logic [SUM_W-1:0] round_shift(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] rnd;
        rnd = SUM_W'(1) << (SHIFT - 1);
        return (s + rnd) >> SHIFT;
    endfunction

    function automatic logic [DATA_W-1:0] sat_u8(input logic [SUM_W-1:0] r);
        return (r > SUM_W'(255)) ? 8'hFF : r[DATA_W-1:0];
    endfunction

    logic [PROD_W-1:0] prod_p1_q [4];
    logic [PROD_W-1:0] prod_p1_d [4];
    logic [SUM_W-1:0]  sum_p2;
    logic [DATA_W-1:0] dout_p2_q, dout_p2_d;
    logic              above_p2_q, above_p2_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              vld_p2_d;
    logic [DATA_W-1:0] peak_q, peak_d;

    // ---- stage 1: products ----
    always_comb begin
        prod_p1_d[0] = {4'd0, tap0} * {8'd0, C0};
        prod_p1_d[1] = {4'd0, tap1} * {8'd0, C1};
        prod_p1_d[2] = {4'd0, tap2} * {8'd0, C2};
        prod_p1_d[3] = {4'd0, tap3} * {8'd0, C3};
    end

    // ---- stage 2: sum, round, saturate, qualify ----
    always_comb begin
        sum_p2 = {2'b00, prod_p1_q[0]} + {2'b00, prod_p1_q[1]}
               + {2'b00, prod_p1_q[2]} + {2'b00, prod_p1_q[3]};
        dout_p2_d = sat_u8(round_shift(sum_p2));
        // Counter saturates, so out_valid stays high until the next reset.
        cnt_d    = (cnt_q == WARM_DONE) ? cnt_q : cnt_q + 3'd1;
        vld_p2_d = (cnt_d == WARM_DONE);
        // Flag tracks the value being registered, gated by the valid it will sit next to.
        above_p2_d = vld_p2_d && (dout_p2_d > thresh);
    end

    // ---- peak hold: operates on the registered output ----
    always_comb begin
        peak_d = peak_q;
        if (peak_clr)
            peak_d = '0;
        else if (out_valid && (dout_p2_q > peak_q))
            peak_d = dout_p2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) prod_p1_q[i] <= '0;
            dout_p2_q  <= '0;
            above_p2_q <= 1'b0;
            cnt_q      <= '0;
            peak_q     <= '0;
        end else begin
            for (int i = 0; i < 4; i++) prod_p1_q[i] <= prod_p1_d[i];
            dout_p2_q  <= dout_p2_d;
            above_p2_q <= above_p2_d;
            cnt_q      <= cnt_d;
            peak_q     <= peak_d;
        end
    end

    assign dout      = dout_p2_q;
    assign above     = above_p2_q;
    assign out_valid = (cnt_q == WARM_DONE);
    assign peak      = peak_q;

endmodule

// File: tb/tb_tap_fir4.sv
module tb_tap_fir4;

    logic       clk;
    logic       reset;
    logic [7:0] tap0, tap1, tap2, tap3;
    logic [7:0] thresh;
    logic       peak_clr;
    logic [7:0] dout, peak, s_dout, s_peak;
    logic       out_valid, above, s_out_valid, s_above;

    int n_checks = 0;
    int n_errors = 0;

    tap_fir4 u_dut (
        .clk(clk), .reset(reset),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
        .thresh(thresh), .peak_clr(peak_clr),
        .dout(dout), .out_valid(out_valid), .above(above), .peak(peak)
    );

    tap_fir4 #(.C0(4'd15), .C1(4'd15), .C2(4'd15), .C3(4'd15), .SHIFT(3)) u_sat (
        .clk(clk), .reset(reset),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
        .thresh(thresh), .peak_clr(peak_clr),
        .dout(s_dout), .out_valid(s_out_valid), .above(s_above), .peak(s_peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_taps(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        tap0 = a; tap1 = b; tap2 = c; tap3 = d;
    endtask

    logic [7:0] imp_exp [6];

    initial begin
        imp_exp[0] = 8'd8;  imp_exp[1] = 8'd16; imp_exp[2] = 8'd16;
        imp_exp[3] = 8'd8;  imp_exp[4] = 8'd0;  imp_exp[5] = 8'd0;

        reset = 1'b0; peak_clr = 1'b0; thresh = 8'd59;
        set_taps(8'd0, 8'd0, 8'd0, 8'd0);
        tick(); tick();
        check("rst_dout", dout, 0);
        check("rst_valid", out_valid, 0);
        check("rst_above", above, 0);
        check("rst_peak", peak, 0);

        // Constant 80 from release: 480 -> (484)>>3 = 60, valid from edge 6
        set_taps(8'd80, 8'd80, 8'd80, 8'd80);
        @(negedge clk); reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("warm_valid_e%0d", k), out_valid, (k >= 6));
            check($sformatf("warm_above_e%0d", k), above, (k >= 6));
            if (k >= 2) check($sformatf("c80_dout_e%0d", k), dout, 60);
            check($sformatf("c80_peak_e%0d", k), peak, (k >= 7) ? 60 : 0);
        end
        check("sat_c80_dout", s_dout, 255);

        // Threshold: equality gives 0
        thresh = 8'd60; tick();
        check("thr_eq", above, 0);
        thresh = 8'd59; tick();
        check("thr_gt", above, 1);

        // Peak-clear collision: taps 255 -> dout 1530+4>>3 = 191
        set_taps(8'd255, 8'd255, 8'd255, 8'd255);
        tick();
        check("col_dout_pre", dout, 60);
        check("col_peak_pre", peak, 60);
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        check("col_dout", dout, 191);
        check("col_peak_clr", peak, 0);
        check("sat_c255_dout", s_dout, 255);
        tick();
        check("col_peak_cap", peak, 191);

        // Saturation: C=15, 200 -> 12000 -> 1500 -> 255; main 1200 -> 150
        set_taps(8'd200, 8'd200, 8'd200, 8'd200);
        tick(); tick();
        check("sat_c200_dout", s_dout, 255);
        check("main_c200_dout", dout, 150);
        check("sat_valid", s_out_valid, 1);

        // Impulse walking tap0 -> tap3, starting from cleared peak
        set_taps(8'd0, 8'd0, 8'd0, 8'd0);
        tick(); tick();
        check("imp_zero", dout, 0);
        peak_clr = 1'b1; tick(); peak_clr = 1'b0;
        check("imp_peak_clr", peak, 0);
        for (int j = 0; j <= 6; j++) begin
            case (j)
                0: set_taps(8'd64, 8'd0, 8'd0, 8'd0);
                1: set_taps(8'd0, 8'd64, 8'd0, 8'd0);
                2: set_taps(8'd0, 8'd0, 8'd64, 8'd0);
                3: set_taps(8'd0, 8'd0, 8'd0, 8'd64);
                default: set_taps(8'd0, 8'd0, 8'd0, 8'd0);
            endcase
            tick();
            if (j >= 1) check($sformatf("imp_dout_%0d", j - 1), dout, imp_exp[j-1]);
        end
        check("imp_peak", peak, 16);

        // Mid-run reset at steady state
        set_taps(8'd80, 8'd80, 8'd80, 8'd80);
        tick(); tick(); tick();
        check("pre_rst_dout", dout, 60);
        check("pre_rst_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_dout", dout, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_above", above, 0);
        check("mid_rst_peak", peak, 0);
        @(negedge clk); reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("rewarm_valid_e%0d", k), out_valid, (k >= 6));
        end
        check("rewarm_dout", dout, 60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tap_fir4.md
Name: tap_fir4

Overview:
- Downstream consumer of the 4-tap delay line (Dout0..Dout3, Dout0 newest).
- Two-stage pipelined 4-tap FIR with constant coefficients, rounding and unsigned saturation to 8 bits.
- Adds a warm-up qualifier, so outputs are flagged valid only once the delay line holds real samples.
- Adds a peak-hold register and a threshold flag for the control path.

Parameters:
- C0, 1, coefficient for tap0 (newest), 4-bit unsigned, 0..15
- C1, 2, coefficient for tap1, 4-bit unsigned
- C2, 2, coefficient for tap2, 4-bit unsigned
- C3, 1, coefficient for tap3 (oldest), 4-bit unsigned
- SHIFT, 3, right-shift applied after rounding, 1..6

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- tap0  input  8  newest sample (delay-line stage 0), unsigned
- tap1  input  8  delay-line stage 1
- tap2  input  8  delay-line stage 2
- tap3  input  8  delay-line stage 3 (oldest)
- thresh  input  8  compare level for above, unsigned
- peak_clr  input  1  synchronous clear of peak
- dout  output  8  filtered, rounded, saturated sample
- out_valid  output  1  dout carries a fully-populated filter result
- above  output  1  out_valid and dout > thresh
- peak  output  8  largest valid dout since reset or last clear

Behaviour:
- Reset is asynchronous and active-low (reset=0). All registers clear to 0: stage-1 products, dout, out_valid, above, peak, warm-up counter.
- Stage 1, edge k:
  - p_i <= tap_i * C_i, i = 0..3.
  - Each product is 12 bits unsigned, zero-extended.
- Stage 2, edge k+1:
  - s = p0+p1+p2+p3, 14 bits.
  - r = (s + 2^(SHIFT-1)) >> SHIFT.
  - dout <= (r > 255) ? 255 : r[7:0].
  - Latency is 2 clocks from taps to dout.
  - No truncation is allowed before saturation: the 14-bit width covers 4*15*255 + 32.
- above:
  - Registered with dout: above <= (r_sat > thresh) using the same edge's values.
  - Forced 0 whenever the next out_valid is 0.
  - Strict greater-than: equality gives 0.
- Warm-up counter:
  - 3-bit, counts rising edges after reset release and saturates at 6.
  - out_valid = (cnt == 6); it rises immediately after the 6th edge (4 edges to fill the delay line plus 2 pipeline edges).
  - out_valid then stays 1 until the next reset.
  - dout still updates during warm-up, computed from zero-filled taps.
- Peak register, updated every edge:
  - If peak_clr: peak <= 0.
  - Else if out_valid and dout > peak: peak <= dout.
  - Else: hold.
  - peak lags dout by one clock.
  - peak_clr has priority over a simultaneous larger dout; that dout is not captured.
  - The next larger valid dout is captured normally.
- Reset mid-operation: the pipeline, counter and peak clear at once. Warm-up restarts from 0, so out_valid is low for 6 edges after release.
- Output width rule: saturation is the only overflow handling; no wrap-around may occur on dout.

Test Plan:
- Reset then constant 80 on all taps from release:
  - out_valid=0 through edge 5, 1 from edge 6.
  - dout=60 (sum 480, +4, >>3).
  - peak=60 one clock after out_valid.
- Impulse: taps sequence of a 64 walking tap0→tap3 then zeros:
  - dout sequence 8, 16, 16, 8, then 0, each 2 clocks after the tap change.
  - peak=16.
- Saturation, C0..C3=15, constant 200 → s=12000, r=1500, dout=255. Constant 255 → dout=255, never wraps.
- Threshold: constant 80, thresh=59 → above=1; thresh=60 → above=0; above=0 during warm-up regardless of thresh.
- Peak clear collision:
  - Setup: peak=60; assert peak_clr for one cycle on the same edge dout first becomes 191 (taps 255).
  - Required: peak=0 after that edge, then 191 on the following edge.
- Mid-run reset: assert reset low for 1 cycle at steady state → dout, out_valid, above and peak become 0 immediately; out_valid returns only after 6 edges post-release.
